// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared constants and types for the PS/2 key event receiver:
//                prefix byte values, frame FSM state encoding, event record.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Prefix bytes folded into the following key event
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Frame receive FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

    // One decoded key action
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_event_t;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_key_event_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_event_rx_if
//  Description : Valid/ready key event stream from the PS/2 receiver to its
//                consumers. master = event source, slave = event consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_event_rx_if;

    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_ext,
        output ev_brk,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_ext,
        input  ev_brk,
        output ev_ready
    );

endinterface : ps2_key_event_rx_if
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_event_fifo
//  Description : Synchronous count-based FIFO for key events. A pop in the
//                same cycle frees a slot for a push into a full FIFO; no
//                empty bypass. Head data reads as zero while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int  FIFO_DEPTH = 8,
    parameter type T          = ps2_event_t
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_push,
    input  wire T     i_data,
    input  wire logic i_pop_ready,
    output logic      o_valid,
    output T          o_data,
    output logic      o_overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH    = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] C_LAST_PTR = AW'(FIFO_DEPTH - 1);

    T              r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_wr;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && i_pop_ready;
    // A simultaneous pop makes room, so a push into a full FIFO still lands
    assign w_wr    = i_push && (!w_full || w_pop);

    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_overflow = i_push && w_full && !w_pop;

    // Storage array: written on every accepted push, no reset needed
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Read/write pointers with wrap at FIFO_DEPTH, and the occupancy count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : ps2_event_fifo
`default_nettype wire

// File: rtl/ps2_key_event_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_event_rx
//  Description : PS/2 keyboard receiver. Synchronises ps2clk/ps2data, frames
//                11-bit words on falling ps2clk edges, validates start/stop/
//                odd parity, folds E0/F0 prefixes into one event per key
//                action and buffers events in a valid/ready FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  wire logic            clock,
    input  wire logic            reset,
    input  wire logic            ps2clk,
    input  wire logic            ps2data,
    ps2_key_event_rx_if.master   ev,
    output logic                 frame_err,
    output logic                 overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] C_TIMEOUT  = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0]    C_LAST_BIT = 4'd10;

    // Synchroniser chains; index 0 is the first stage
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;

    logic w_fall;
    logic w_data;

    // Frame FSM and datapath
    ps2_state_e r_state;
    ps2_state_e w_state_nxt;
    logic [3:0]    r_bitcnt;
    logic [10:0]   r_frame;
    logic [TW-1:0] r_timer;

    logic       w_timeout;
    logic       w_frame_good;
    logic       w_byte_ok;
    logic       w_check_err;
    logic [7:0] w_byte;

    // Prefix decoder and FIFO write port
    logic       r_ext_f;
    logic       r_brk_f;
    logic       r_push;
    ps2_event_t r_push_ev;
    ps2_event_t w_head;
    logic       w_head_valid;

    // Bring the raw PS/2 lines into the clock domain; idle bus level is 1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2data};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall = r_clk_prev && !r_clk_sync[SYNC_STAGES-1];
    assign w_data = r_dat_sync[SYNC_STAGES-1];

    // Start must be 0, stop 1, and bits 1..9 carry odd parity
    assign w_frame_good = !r_frame[0] && r_frame[10] && (^r_frame[9:1]);
    assign w_byte       = r_frame[8:1];

    // Frame FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame FSM next-state, check and timeout decisions
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_byte_ok   = 1'b0;
        w_check_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = RECV;
                end
            end
            RECV: begin
                if (w_fall) begin
                    if (r_bitcnt == C_LAST_BIT) begin
                        w_state_nxt = CHECK;
                    end
                end else if (r_timer == C_TIMEOUT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            CHECK: begin
                w_state_nxt = IDLE;
                w_byte_ok   = w_frame_good;
                w_check_err = !w_frame_good;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign frame_err = w_check_err || w_timeout;

    // Bit shifter, bit counter and inter-edge timeout counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bitcnt <= '0;
            r_frame  <= '0;
            r_timer  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    if (w_fall) begin
                        r_frame[r_bitcnt] <= w_data;
                        r_bitcnt          <= r_bitcnt + 4'd1;
                    end
                end
                RECV: begin
                    if (w_fall) begin
                        r_frame[r_bitcnt] <= w_data;
                        r_bitcnt          <= r_bitcnt + 4'd1;
                        r_timer           <= '0;
                    end else if (w_timeout) begin
                        r_bitcnt <= '0;
                        r_timer  <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_bitcnt <= '0;
                    r_timer  <= '0;
                end
            endcase
        end
    end

    // Fold E0/F0 prefixes into the next key byte; any error drops them
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ext_f   <= 1'b0;
            r_brk_f   <= 1'b0;
            r_push    <= 1'b0;
            r_push_ev <= '0;
        end else begin
            r_push <= 1'b0;
            if (frame_err) begin
                r_ext_f <= 1'b0;
                r_brk_f <= 1'b0;
            end else if (w_byte_ok) begin
                if (w_byte == PS2_EXT) begin
                    r_ext_f <= 1'b1;
                end else if (w_byte == PS2_BRK) begin
                    r_brk_f <= 1'b1;
                end else begin
                    r_push         <= 1'b1;
                    r_push_ev.code <= w_byte;
                    r_push_ev.ext  <= r_ext_f;
                    r_push_ev.brk  <= r_brk_f;
                    r_ext_f        <= 1'b0;
                    r_brk_f        <= 1'b0;
                end
            end
        end
    end

    ps2_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .T          (ps2_event_t)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (r_push),
        .i_data      (r_push_ev),
        .i_pop_ready (ev.ev_ready),
        .o_valid     (w_head_valid),
        .o_data      (w_head),
        .o_overflow  (overflow)
    );

    assign ev.ev_valid = w_head_valid;
    assign ev.ev_code  = w_head.code;
    assign ev.ev_ext   = w_head.ext;
    assign ev.ev_brk   = w_head.brk;

endmodule : ps2_key_event_rx
`default_nettype wire

// File: tb/tb_ps2_key_event_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_event_rx
//  Description : Directed self-checking bench for ps2_key_event_rx
//                (TIMEOUT_CYCLES=100, FIFO_DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_rx;
    import ps2_pkg::*;

    localparam int H = 10;   // PS/2 half bit period in system clocks

    logic clock   = 1'b0;
    logic reset   = 1'b0;
    logic ps2clk  = 1'b1;
    logic ps2data = 1'b1;
    logic frame_err;
    logic overflow;

    ps2_key_event_rx_if u_if ();

    ps2_key_event_rx #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (100),
        .FIFO_DEPTH     (4)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .ps2clk    (ps2clk),
        .ps2data   (ps2data),
        .ev        (u_if),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_fall_cyc = 0;

    logic [9:0] ev_q[$];
    int         ev_cyc_q[$];
    int ferr_cnt  = 0;
    int ferr_last = 0;
    int ovf_cnt   = 0;
    int ovf_last  = 0;
    int valid_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Observe accepted events and pulses away from the active edge
    always @(negedge clock) begin
        if (u_if.ev_valid === 1'b1) valid_cnt++;
        if (u_if.ev_valid === 1'b1 && u_if.ev_ready === 1'b1) begin
            ev_q.push_back({u_if.ev_code, u_if.ev_ext, u_if.ev_brk});
            ev_cyc_q.push_back(cyc);
        end
        if (frame_err === 1'b1) begin
            ferr_cnt++;
            ferr_last = cyc;
        end
        if (overflow === 1'b1) begin
            ovf_cnt++;
            ovf_last = cyc;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2data = f[i];
            tick(H);
            ps2clk = 1'b0;
            last_fall_cyc = cyc;
            tick(H);
            ps2clk = 1'b1;
        end
        ps2data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        send_bits(mk_frame(b, flip), 11);
    endtask

    function automatic logic [9:0] ev_at(input int idx);
        if (idx < ev_q.size()) return ev_q[idx];
        return 10'h3FF;
    endfunction

    task automatic test_reset;
        u_if.ev_ready = 1'b0;
        reset = 1'b0;
        tick(3);
        n_tests++;
        if ({u_if.ev_valid, u_if.ev_code, u_if.ev_ext, u_if.ev_brk} !== 11'h0) begin
            $display("FAIL reset_ev: got %b want 0", {u_if.ev_valid, u_if.ev_code, u_if.ev_ext, u_if.ev_brk});
            n_fail++;
        end
        n_tests++;
        if ({frame_err, overflow} !== 2'b00) begin
            $display("FAIL reset_pulses: got %b want 00", {frame_err, overflow});
            n_fail++;
        end
        reset = 1'b1;
        tick(3);
    endtask

    task automatic test_single;
        int base = ev_q.size();
        int v0   = valid_cnt;
        u_if.ev_ready = 1'b1;
        send_frame(8'h1C, 1'b0);
        tick(5);
        n_tests++;
        if (ev_q.size() - base !== 1) begin
            $display("FAIL single_count: got %0d want 1", ev_q.size() - base);
            n_fail++;
        end
        n_tests++;
        if (ev_at(base) !== {8'h1C, 1'b0, 1'b0}) begin
            $display("FAIL single_event: got %h want %h", ev_at(base), {8'h1C, 1'b0, 1'b0});
            n_fail++;
        end
        // E is the first posedge after the 11th fall is driven
        n_tests++;
        if (ev_q.size() > base && ev_cyc_q[base] - (last_fall_cyc + 1) !== 4) begin
            $display("FAIL single_latency: got %0d want 4", ev_cyc_q[base] - (last_fall_cyc + 1));
            n_fail++;
        end
        n_tests++;
        if (valid_cnt - v0 !== 1) begin
            $display("FAIL single_valid_cycles: got %0d want 1", valid_cnt - v0);
            n_fail++;
        end
    endtask

    task automatic test_break;
        int base = ev_q.size();
        send_frame(8'hF0, 1'b0);
        tick(5);
        n_tests++;
        if (ev_q.size() - base !== 0) begin
            $display("FAIL break_prefix_silent: got %0d events want 0", ev_q.size() - base);
            n_fail++;
        end
        send_frame(8'h1C, 1'b0);
        tick(5);
        n_tests++;
        if (ev_q.size() - base !== 1 || ev_at(base) !== {8'h1C, 1'b0, 1'b1}) begin
            $display("FAIL break_event: got n=%0d ev=%h want n=1 ev=%h", ev_q.size() - base, ev_at(base), {8'h1C, 1'b0, 1'b1});
            n_fail++;
        end
    endtask

    task automatic test_ext_break;
        int base = ev_q.size();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'h1C, 1'b0);
        tick(5);
        n_tests++;
        if (ev_q.size() - base !== 2) begin
            $display("FAIL extbrk_count: got %0d want 2", ev_q.size() - base);
            n_fail++;
        end
        n_tests++;
        if (ev_at(base) !== {8'h75, 1'b1, 1'b1}) begin
            $display("FAIL extbrk_event: got %h want %h", ev_at(base), {8'h75, 1'b1, 1'b1});
            n_fail++;
        end
        n_tests++;
        if (ev_at(base + 1) !== {8'h1C, 1'b0, 1'b0}) begin
            $display("FAIL extbrk_flags_cleared: got %h want %h", ev_at(base + 1), {8'h1C, 1'b0, 1'b0});
            n_fail++;
        end
    endtask

    task automatic test_parity;
        int base = ev_q.size();
        int f0   = ferr_cnt;
        send_frame(8'hF0, 1'b0);      // pending break must be discarded by the error
        send_frame(8'h1C, 1'b1);
        tick(5);
        n_tests++;
        if (ferr_cnt - f0 !== 1 || ev_q.size() - base !== 0) begin
            $display("FAIL parity_err: got err=%0d ev=%0d want err=1 ev=0", ferr_cnt - f0, ev_q.size() - base);
            n_fail++;
        end
        send_frame(8'h32, 1'b0);
        tick(5);
        n_tests++;
        if (ev_at(base) !== {8'h32, 1'b0, 1'b0}) begin
            $display("FAIL parity_recover: got %h want %h", ev_at(base), {8'h32, 1'b0, 1'b0});
            n_fail++;
        end
    endtask

    task automatic test_timeout;
        int base = ev_q.size();
        int f0   = ferr_cnt;
        int fc;
        send_bits(mk_frame(8'h5A, 1'b0), 5);
        fc = last_fall_cyc;
        tick(120);
        n_tests++;
        if (ferr_cnt - f0 !== 1) begin
            $display("FAIL timeout_pulse: got %0d pulses want 1", ferr_cnt - f0);
            n_fail++;
        end
        // ~100 idle cycles after the last fall, plus synchroniser delay
        n_tests++;
        if (ferr_last - fc < 98 || ferr_last - fc > 106) begin
            $display("FAIL timeout_time: got %0d cycles want 98..106", ferr_last - fc);
            n_fail++;
        end
        send_frame(8'h1C, 1'b0);
        tick(5);
        n_tests++;
        if (ev_at(base) !== {8'h1C, 1'b0, 1'b0} || ferr_cnt - f0 !== 1) begin
            $display("FAIL timeout_recover: got ev=%h err=%0d want ev=%h err=1", ev_at(base), ferr_cnt - f0, {8'h1C, 1'b0, 1'b0});
            n_fail++;
        end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_codes [4];
        int base = ev_q.size();
        int o0   = ovf_cnt;
        int fc;
        exp_codes[0] = 8'h1C;
        exp_codes[1] = 8'h32;
        exp_codes[2] = 8'h21;
        exp_codes[3] = 8'h23;
        u_if.ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(exp_codes[i], 1'b0);
        tick(5);
        n_tests++;
        if (ovf_cnt - o0 !== 0 || u_if.ev_valid !== 1'b1) begin
            $display("FAIL ovf_fill: got ovf=%0d valid=%b want ovf=0 valid=1", ovf_cnt - o0, u_if.ev_valid);
            n_fail++;
        end
        send_frame(8'h24, 1'b0);
        fc = last_fall_cyc;
        tick(5);
        n_tests++;
        if (ovf_cnt - o0 !== 1 || ovf_last <= fc) begin
            $display("FAIL ovf_pulse: got %0d pulses last=%0d want 1 after %0d", ovf_cnt - o0, ovf_last, fc);
            n_fail++;
        end
        u_if.ev_ready = 1'b1;
        tick(10);
        n_tests++;
        if (ev_q.size() - base !== 4) begin
            $display("FAIL ovf_drain_count: got %0d want 4", ev_q.size() - base);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (ev_at(base + i) !== {exp_codes[i], 1'b0, 1'b0}) begin
                $display("FAIL ovf_order[%0d]: got %h want %h", i, ev_at(base + i), {exp_codes[i], 1'b0, 1'b0});
                n_fail++;
            end
        end
        n_tests++;
        if (u_if.ev_valid !== 1'b0 || u_if.ev_code !== 8'h00) begin
            $display("FAIL ovf_empty: got valid=%b code=%h want 0/00", u_if.ev_valid, u_if.ev_code);
            n_fail++;
        end
    endtask

    task automatic test_reset_midframe;
        int base;
        int f0;
        u_if.ev_ready = 1'b0;
        send_frame(8'h1C, 1'b0);
        send_bits(mk_frame(8'h5A, 1'b0), 4);
        reset = 1'b0;
        tick(2);
        n_tests++;
        if (u_if.ev_valid !== 1'b0) begin
            $display("FAIL midreset_flush: got valid=%b want 0", u_if.ev_valid);
            n_fail++;
        end
        reset = 1'b1;
        tick(2);
        base = ev_q.size();
        f0   = ferr_cnt;
        u_if.ev_ready = 1'b1;
        send_frame(8'h32, 1'b0);
        tick(5);
        n_tests++;
        if (ev_q.size() - base !== 1 || ev_at(base) !== {8'h32, 1'b0, 1'b0} || ferr_cnt - f0 !== 0) begin
            $display("FAIL midreset_recover: got n=%0d ev=%h err=%0d want n=1 ev=%h err=0", ev_q.size() - base, ev_at(base), ferr_cnt - f0, {8'h32, 1'b0, 1'b0});
            n_fail++;
        end
    endtask

    initial begin
        u_if.ev_ready = 1'b0;
        test_reset();
        test_single();
        test_break();
        test_ext_break();
        test_parity();
        test_timeout();
        test_overflow();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ps2_key_event_rx
`default_nettype wire

// File: doc/ps2_key_event_rx.md
# ps2_key_event_rx

Parametrised PS/2 keyboard receiver for the Morse translator front end. It samples `ps2clk`/`ps2data` in the system `clock` domain and checks every 11-bit frame (start, parity, stop). It folds the E0 (extended) and F0 (break) prefixes into one key event per key action, and buffers events in a FIFO with a valid/ready output. Downstream consumers (letter decoder, 7-segment driver, Morse buzzer sequencer) pop events instead of re-parsing raw frames.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth on `ps2clk` and `ps2data`, minimum 2.
- `TIMEOUT_CYCLES`, 50000: `clock` cycles without a falling `ps2clk` edge, mid-frame, before the frame is aborted. Default is 1 ms at 50 MHz.
- `FIFO_DEPTH`, 8: event FIFO depth, power of two, ≥2.

Ports:
- `clock`, in, 1: system clock, single clock domain.
- `reset`, in, 1: asynchronous, active-low reset.
- `ps2clk`, in, 1: raw PS/2 clock, asynchronous.
- `ps2data`, in, 1: raw PS/2 data, asynchronous.
- `ev_valid`, out, 1: FIFO non-empty.
- `ev_ready`, in, 1: consumer accepts the head event.
- `ev_code`, out, 8: scan code of the head event.
- `ev_ext`, out, 1: head event was E0-prefixed.
- `ev_brk`, out, 1: head event is a release (F0-prefixed).
- `frame_err`, out, 1: one-cycle pulse on a parity, start, stop or timeout error.
- `overflow`, out, 1: one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Both inputs pass through `SYNC_STAGES` flops. A falling edge means synced `ps2clk` was 1 on the previous cycle and is 0 now.
- At each falling edge, the synced `ps2data` is shifted into bit `bitcnt` of an 11-bit frame register, and `bitcnt` increments. Bit 0 is the start bit, bits 1–8 are data LSB-first, bit 9 is parity, bit 10 is stop.
- Frame FSM states: `IDLE` (bitcnt 0) → `RECV` (bitcnt 1..10) → `CHECK` (one cycle) → `IDLE`.
- `CHECK` requires start=0, stop=1, and odd parity over bits 1–9. On failure it pulses `frame_err`, clears the prefix flags and emits nothing.
- Prefix decoder, on each good byte:
  - 0xE0 sets `ext_f`.
  - 0xF0 sets `brk_f`.
  - Any other byte emits {code, `ext_f`, `brk_f`} to the FIFO and clears both flags.
  - Repeated prefixes are idempotent.
- Timeout: in `RECV`, a counter runs from the last falling edge. When it reaches `TIMEOUT_CYCLES` the FSM returns to `IDLE`, `bitcnt` goes to 0, `frame_err` pulses, and the prefix flags clear.
- FIFO:
  - A pop happens when `ev_valid && ev_ready`.
  - Push while full: the event is dropped and `overflow` pulses. Exception: a pop in the same cycle frees a slot, so the push succeeds with no overflow.
  - Push and pop on the same cycle while empty: no bypass. The push lands and `ev_valid` rises the next cycle.
  - Order is strictly FIFO.
- `ev_code`, `ev_ext` and `ev_brk` are meaningful only while `ev_valid` is high. When empty they hold 0.
- Reset values: `ev_valid`, `ev_code`, `ev_ext`, `ev_brk`, `frame_err`, `overflow` all 0. FIFO empty, FSM `IDLE`, flags clear, synchroniser flops at 1 (bus idle).
- Reset asserted mid-frame discards the partial frame and all buffered events.

## Timing
- Let cycle E be the first `clock` edge at which the raw `ps2clk` 11th-bit low level is captured by synchroniser stage 1.
- The falling edge is detected at E+`SYNC_STAGES`−1; `CHECK` occurs at E+`SYNC_STAGES`; the FIFO write lands at E+`SYNC_STAGES`+1.
- For an event-emitting byte, `ev_valid` is high at E+`SYNC_STAGES`+2. With the default this is 4 cycles.
- `frame_err` pulses in the `CHECK` cycle, or in the cycle the timeout counter hits `TIMEOUT_CYCLES`.
- `overflow` pulses in the attempted-write cycle.
- Throughput: one event per PS/2 frame. The FIFO accepts one push and one pop per cycle.

## Structure
- Shared package `ps2_pkg` holds:
  - constants `PS2_EXT` = 8'hE0 and `PS2_BRK` = 8'hF0;
  - the frame FSM state enum;
  - a packed struct `ps2_event_t` {code[7:0], ext, brk}, 10 bits.
- One sub-module, `ps2_event_fifo`: synchronous, parametrised by `FIFO_DEPTH` and the element type. It uses a count-based full/empty with pointer wrap at `FIFO_DEPTH`.

## Test plan
- Single frame 0x1C (correct parity), `ev_ready`=1 → one event: code 0x1C, ext 0, brk 0. `ev_valid` high for exactly one cycle, 4 cycles after the 11th edge.
- Frames F0, 1C → exactly one event: code 0x1C, brk 1, ext 0. No event for the F0 frame.
- Frames E0, F0, 75 → one event: code 0x75, ext 1, brk 1. A following frame 1C → ext 0, brk 0.
- Frame 0x1C with parity bit flipped → `frame_err` pulse, no event. Next good frame 0x32 → event code 0x32.
- `TIMEOUT_CYCLES`=100: 5 bits, then idle for 120 cycles → `frame_err` pulse at idle cycle 100. Next full frame 0x1C decodes correctly.
- `FIFO_DEPTH`=4, `ev_ready`=0: send 1C, 32, 21, 23, 24 → `overflow` pulses once, on 24. Then raise `ev_ready` → pops in order 1C, 32, 21, 23, after which `ev_valid` drops to 0.
